// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: resolved-instruction
// kinds, 2-bit direction counter states, per-entry metadata and the
// saturating counter step.
package bp_pkg;

  typedef enum logic [1:0] {
    KIND_BR  = 2'd0,  // conditional branch
    KIND_JMP = 2'd1,  // jal / jalr
    KIND_RET = 2'd2,  // return
    KIND_RSV = 2'd3   // reserved, never trained
  } kind_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Control part of a BTB entry. Tag and target widths depend on the top's
  // parameters, so they live in parallel arrays next to this struct.
  typedef struct packed {
    logic       valid;
    kind_e      kind;
    logic [1:0] ctr;
  } entry_meta_t;

  // Saturating 2-bit counter step towards the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack. Push-when-full overwrites the oldest entry,
// pop-when-empty is ignored, push+pop together replaces the top entry.
module bp_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   tp_q, tp_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_ptr;

  assign top   = stack_q[tp_q];
  assign empty = (cnt_q == '0);

  // Next pointer/count and which slot, if any, receives push_addr.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tp_q;
    if (push && pop && !empty) begin
      wr_en = 1'b1;
    end else if (push) begin
      tp_d   = tp_q + PW'(1);
      wr_ptr = tp_d;
      wr_en  = 1'b1;
      if (cnt_q != (PW+1)'(DEPTH)) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops sample before any update.
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy alone decides which slots are meaningful.
    if (wr_en) stack_q[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: same-cycle prediction
// from pc, one training update per cycle from execute.
// Optional feature macro: BP_RAS_EN adds a return-address stack for returns.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_kind,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_call,
  input  logic            flush
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  entry_meta_t     meta_q [ENTRIES];
  logic [TAGW-1:0] tag_q  [ENTRIES];
  logic [XLEN-1:0] tgt_q  [ENTRIES];

  logic [IDX-1:0]  lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag, upd_tag;
  entry_meta_t     lk_meta, upd_meta, meta_d;
  logic [XLEN-1:0] pc_plus4;
  logic            upd_hit, upd_en, wr_meta, wr_data;
  kind_e           kind;

  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  assign lk_idx   = pc[IDX+1:2];
  assign lk_tag   = pc[XLEN-1:IDX+2];
  assign lk_meta  = meta_q[lk_idx];
  assign pc_plus4 = pc + XLEN'(4);

  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[XLEN-1:IDX+2];
  assign upd_meta = meta_q[upd_idx];
  assign kind     = kind_e'(upd_kind);
  assign upd_hit  = upd_meta.valid && (tag_q[upd_idx] == upd_tag);
  // A flush in the same cycle drops the update, including any RAS activity.
  assign upd_en   = upd_valid && !flush && (kind != KIND_RSV);

`ifdef BP_RAS_EN
  bp_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_en && upd_call),
    .pop       (upd_en && (kind == KIND_RET)),
    .push_addr (upd_pc + XLEN'(4)),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{upd_call, upd_pc[1:0], ras_top, ras_empty};
`endif

  // Combinational lookup; a return hit prefers a non-empty RAS top.
  always_comb begin
    pred_hit    = lk_meta.valid && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ((lk_meta.kind != KIND_BR) || lk_meta.ctr[1]);
    pred_target = pred_taken ? tgt_q[lk_idx] : pc_plus4;
    if (pred_hit && (lk_meta.kind == KIND_RET) && !ras_empty) begin
      pred_taken  = 1'b1;
      pred_target = ras_top;
    end
  end

  // Training decision: counter/kind update on hit, allocation on taken miss.
  always_comb begin
    meta_d  = upd_meta;
    wr_meta = 1'b0;
    wr_data = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        wr_meta     = 1'b1;
        meta_d.kind = kind;
        if (kind == KIND_BR) begin
          meta_d.ctr = ctr_next(upd_meta.ctr, upd_taken);
          wr_data    = upd_taken;
        end else begin
          meta_d.ctr = CTR_ST;
          wr_data    = 1'b1;
        end
      end else if (upd_taken) begin
        wr_meta = 1'b1;
        wr_data = 1'b1;
        meta_d  = '{valid: 1'b1, kind: kind,
                    ctr: (kind == KIND_BR) ? CTR_WT : CTR_ST};
      end
    end
  end

  // Entry control state: reset and flush invalidate every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) meta_q[i] <= '{valid: 1'b0, kind: KIND_BR, ctr: CTR_SNT};
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) meta_q[i].valid <= 1'b0;
    end else if (wr_meta) begin
      meta_q[upd_idx] <= meta_d;
    end
  end

  // Tag and target storage, only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (wr_data) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed-vector bench for branch_predictor_btb. The RAS section runs only
// when the bench is built with BP_RAS_EN.
module tb_branch_predictor_btb;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_call;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor_btb #(
    .XLEN      (32),
    .ENTRIES   (16),
    .RAS_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_kind    (upd_kind),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_call    (upd_call),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One training update, driven on the falling edge and taken at the next rising edge.
  task automatic upd(input logic [31:0] a, input logic [1:0] k, input logic t,
                     input logic [31:0] tgt, input logic call);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = a; upd_kind = k; upd_taken = t;
    upd_target = tgt; upd_call = call;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_call = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic h,
                      input logic t, input logic [31:0] tgt);
    pc = a;
    #1;
    check({tag, "_hit"},    32'(pred_hit),   32'(h));
    check({tag, "_taken"},  32'(pred_taken), 32'(t));
    check({tag, "_target"}, pred_target,     tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_kind = '0;
    upd_taken = 1'b0; upd_target = '0; upd_call = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    look("reset", 32'h100, 1'b0, 1'b0, 32'h104);

    // Branch counter walk at 0x100: allocate WT, down to SNT, saturate, back up.
    upd(32'h100, KIND_BR, 1'b1, 32'h80, 1'b0);
    look("br_alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    look("br_wnt", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    look("br_snt", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    upd(32'h100, KIND_BR, 1'b1, 32'h80, 1'b0);
    look("br_sat_lo", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, KIND_BR, 1'b1, 32'h80, 1'b0);
    look("br_up_wt", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, KIND_BR, 1'b1, 32'h80, 1'b0);
    upd(32'h100, KIND_BR, 1'b1, 32'h80, 1'b0);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    look("br_sat_hi", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, KIND_BR, 1'b0, 32'h999, 1'b0);
    look("br_down_wnt", 32'h100, 1'b1, 1'b0, 32'h104);

    // Jump retrains the entry, then an aliasing jump evicts it.
    upd(32'h100, KIND_JMP, 1'b1, 32'h200, 1'b0);
    look("jmp_hit", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h140, KIND_JMP, 1'b1, 32'h300, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Not-taken branch miss and reserved kind allocate nothing.
    upd(32'h184, KIND_BR, 1'b0, 32'h999, 1'b0);
    look("nt_miss", 32'h184, 1'b0, 1'b0, 32'h188);
    upd(32'h24, KIND_RSV, 1'b1, 32'h999, 1'b0);
    look("rsv", 32'h24, 1'b0, 1'b0, 32'h28);

    // Same-cycle lookup sees old contents; next cycle sees the update.
    @(negedge clk);
    pc = 32'h140;
    upd_valid = 1'b1; upd_pc = 32'h140; upd_kind = KIND_JMP;
    upd_taken = 1'b1; upd_target = 32'h3C0;
    #1 check("bypass_old", pred_target, 32'h300);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    check("bypass_new", pred_target, 32'h3C0);

    // Flush wins over a simultaneous update.
    @(negedge clk);
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_kind = KIND_JMP;
    upd_taken = 1'b1; upd_target = 32'h500;
    @(posedge clk);
    #1 flush = 1'b0; upd_valid = 1'b0;
    look("flush_upd", 32'h100, 1'b0, 1'b0, 32'h104);
    look("flush_old", 32'h140, 1'b1 ^ 1'b1, 1'b0, 32'h144);

    // Return entry with an empty (or absent) RAS uses the stored target.
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ret_stored", 32'h0C, 1'b1, 1'b1, 32'h444);

`ifdef BP_RAS_EN
    // Five calls into a depth-4 stack keep the newest four.
    for (int i = 1; i <= 5; i++) upd(32'(i * 16), KIND_JMP, 1'b1, 32'h1000, 1'b1);
    look("ras_top", 32'h0C, 1'b1, 1'b1, 32'h54);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_pop1", 32'h0C, 1'b1, 1'b1, 32'h44);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_pop2", 32'h0C, 1'b1, 1'b1, 32'h34);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_pop3", 32'h0C, 1'b1, 1'b1, 32'h24);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_empty", 32'h0C, 1'b1, 1'b1, 32'h444);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_pop_empty", 32'h0C, 1'b1, 1'b1, 32'h444);
    // Push+pop: pushes when empty, replaces the top otherwise.
    upd(32'h70, KIND_RET, 1'b1, 32'h444, 1'b1);
    look("ras_pp_empty", 32'h0C, 1'b1, 1'b1, 32'h74);
    upd(32'h80, KIND_RET, 1'b1, 32'h444, 1'b1);
    look("ras_pp_top", 32'h0C, 1'b1, 1'b1, 32'h84);
    upd(32'h0C, KIND_RET, 1'b1, 32'h444, 1'b0);
    look("ras_pp_count", 32'h0C, 1'b1, 1'b1, 32'h444);
`endif

    // Asynchronous reset between clock edges clears predictions at once.
    @(negedge clk);
    pc = 32'h0C;
    #1 check("pre_rst_hit", 32'(pred_hit), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_hit",    32'(pred_hit),   32'h0);
    check("async_rst_taken",  32'(pred_taken), 32'h0);
    check("async_rst_target", pred_target,     32'h10);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters per entry. It generalises the resolve-time target computation into a predict-at-fetch / train-at-execute structure. Fetch gets a same-cycle predicted next PC. Execute writes resolved outcomes back one update per cycle. An optional return-address stack predicts `jalr` returns.

## Interface
Parameters:
- `XLEN`, 32, address width.
- `ENTRIES`, 16, number of BTB entries; power of two, ≥2.
- `RAS_DEPTH`, 4, return-stack depth; power of two. Used only with `BP_RAS_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  XLEN  fetch PC, word aligned.
- `pred_hit`  out  1  valid entry with matching tag.
- `pred_taken`  out  1  predicted redirect.
- `pred_target`  out  XLEN  predicted next PC.
- `upd_valid`  in  1  resolved control-flow instruction this cycle.
- `upd_pc`  in  XLEN  PC of the resolved instruction.
- `upd_kind`  in  2  0 = branch, 1 = jump (`jal`/`jalr`), 2 = return, 3 = reserved (ignored).
- `upd_taken`  in  1  actual direction; always 1 for kinds 1 and 2.
- `upd_target`  in  XLEN  actual target (bit 0 already cleared).
- `upd_call`  in  1  instruction writes `x1`/`x5` as link (RAS push).
- `flush`  in  1  synchronous invalidate of all entries (`fence.i`).

## Operation
- Index = `pc[IDX+1:2]`, where IDX = log2(ENTRIES). Tag = `pc[XLEN-1:IDX+2]`. Each entry holds: valid, tag, kind, target, ctr[1:0].
- Lookup is combinational from `pc`:
  - `pred_hit` = valid && tag match.
  - `pred_taken` = hit && (kind≠branch || ctr[1]).
  - `pred_target` = stored target if `pred_taken`, else `pc+4` (mod 2^XLEN).
- Update when `upd_valid` and kind≠3:
  - Hit, branch: ctr saturating +1 if taken, −1 if not. Target is overwritten only when taken.
  - Hit, jump/return: target overwritten. ctr forced to 2'b11.
  - Miss and taken: allocate, overwriting any valid entry. ctr = 2'b10 for a branch, 2'b11 otherwise.
  - Miss and not taken: no allocation.
- Saturation: ctr 11 + taken stays 11; ctr 00 + not-taken stays 00.
- `flush` clears all valid bits. If `flush` and `upd_valid` occur in the same cycle, `flush` wins and the update is dropped.
- Reset clears all valid bits, ctr to 00, and RAS pointer/count to 0. Target and tag contents are don't-care.

## Timing
- Prediction: 0-cycle latency, same cycle as `pc`.
- Update: visible to lookups from the cycle after `upd_valid`. There is no same-cycle bypass; a lookup to the index being written returns the old contents.
- After reset or flush: `pred_hit`=0, `pred_taken`=0, `pred_target`=`pc+4`.
- Reset asserted mid-operation discards any in-flight update.

## Configuration
- `BP_RAS_EN` defined:
  - Circular RAS of `RAS_DEPTH` entries.
  - Push is done at update time and pushes `upd_pc+4`.
  - When a lookup hits a kind=return entry and the RAS is non-empty, `pred_target` = RAS top and `pred_taken`=1. If the RAS is empty, the stored target is used.
  - Pop occurs on update with kind=return.
  - Push and pop in the same update (`upd_call` with kind=return) overwrites the top entry; count unchanged, or push if empty.
  - Push when full wraps and overwrites the oldest entry; count saturates at `RAS_DEPTH`.
  - Pop when empty is ignored.
  - `flush` does not clear the RAS.
- `BP_RAS_EN` undefined: no RAS storage. Returns are predicted from the stored target exactly like jumps. `upd_call` is ignored.

## Structure
- `bp_pkg`: `upd_kind` encodings (BR, JMP, RET), counter constants (SNT=00, WNT=01, WT=10, ST=11), and the entry struct.
- Sub-module `bp_ras`: ports `clk`, `rst`, `push`, `pop`, `push_addr`, `top`, `empty`. Instantiated only under `BP_RAS_EN`.

## Test plan
- Reset, then `pc`=0x100 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0x104.
- Update taken branch (`upd_pc`=0x100, target 0x80), then look up 0x100 → hit, taken, 0x80. Then apply two not-taken updates → `pred_taken`=0, `pred_target`=0x104. Then apply two more not-taken updates → ctr stays 00.
- With ENTRIES=16, jump at 0x100 to 0x200, then jump at 0x140 (same index) to 0x300 → lookup 0x100 misses; lookup 0x140 predicts 0x300.
- Update at 0x100 while `pc`=0x100 in the same cycle → old prediction in that cycle, new prediction in the next. Assert `flush` together with an update → entry remains invalid.
- `BP_RAS_EN`, RAS_DEPTH=4:
  - Calls at 0x10, 0x20, 0x30, 0x40, 0x50 → RAS holds 0x54/0x44/0x34/0x24.
  - Five return updates → the fifth pop is ignored.
  - Return entry hit with non-empty RAS → `pred_target` = RAS top.
- Assert `rst` asynchronously mid-cycle after training → outputs immediately show miss, `pred_target`=`pc+4`.
